// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble: binary bin_in -> DIGITS packed BCD digits, optional raw hex passthrough.
// Latency: done pulses BIN_WIDTH edges after the accepting edge (decimal) or 1 edge after it (bypass).
// Backpressure: none; start is only accepted while idle, and a start seen while busy is dropped.
module bin_to_bcd_seq #(
    parameter int BIN_WIDTH = 27,
    parameter int DIGITS    = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  hex_bypass,
    input  logic [BIN_WIDTH-1:0]  bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SCR_W = BCD_W + BIN_WIDTH;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    // Largest value that still fits in DIGITS decimal digits.
    localparam logic [BIN_WIDTH-1:0] MAX_DEC   = BIN_WIDTH'(pow10(DIGITS) - 64'd1);
    localparam logic [BCD_W-1:0]     ALL_NINES = {DIGITS{4'h9}};
    localparam logic [CNT_W-1:0]     LAST_STEP = CNT_W'(BIN_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        BYPASS = 2'd2
    } state_t;

    state_t             state;
    logic [SCR_W-1:0]   scratch;
    logic [SCR_W-1:0]   adjusted;
    logic [SCR_W-1:0]   shifted;
    logic [CNT_W-1:0]   step;
    logic               ovf_pending;

    // One double-dabble step: add 3 to every BCD nibble >= 5 (no inter-nibble carry), then shift left.
    always_comb begin
        adjusted = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[BIN_WIDTH + 4*d +: 4] >= 4'd5) begin
                adjusted[BIN_WIDTH + 4*d +: 4] = scratch[BIN_WIDTH + 4*d +: 4] + 4'd3;
            end
        end
        shifted = {adjusted[SCR_W-2:0], 1'b0};
    end

    // Control FSM; outputs are registered so the display only ever sees finished results.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            scratch     <= '0;
            step        <= '0;
            ovf_pending <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            bcd_out     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        scratch <= {{BCD_W{1'b0}}, bin_in};
                        busy    <= 1'b1;
                        if (hex_bypass) begin
                            state <= BYPASS;
                        end else begin
                            ovf_pending <= (bin_in > MAX_DEC);
                            step        <= '0;
                            state       <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    scratch <= shifted;
                    step    <= step + CNT_W'(1);
                    if (step == LAST_STEP) begin
                        // Out-of-range inputs saturate so the display never shows a wrapped value.
                        bcd_out  <= ovf_pending ? ALL_NINES : shifted[SCR_W-1 -: BCD_W];
                        overflow <= ovf_pending;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                BYPASS: begin
                    // Raw value; nibbles above 9 are shown as hex digits downstream.
                    bcd_out  <= BCD_W'(scratch[BIN_WIDTH-1:0]);
                    overflow <= 1'b0;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: directed vectors, a cycle-level behavioural model, per-cycle compare.
// Latency: expects done 27 edges after acceptance (decimal) and 1 edge after (bypass).
// Backpressure: exercises starts issued while busy and start held through done.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        hex_bypass;
    logic [26:0] bin_in;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [31:0] bcd_out;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    bin_to_bcd_seq #(
        .BIN_WIDTH (27),
        .DIGITS    (8)
    ) dut (
        .clock      (clk),
        .reset_n    (rst_n),
        .start      (start),
        .hex_bypass (hex_bypass),
        .bin_in     (bin_in),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .bcd_out    (bcd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal digits by plain division; values past 8 digits saturate.
    function automatic logic [31:0] dec_digits(input logic [26:0] v);
        int          x;
        logic [31:0] r;
        x = int'(v);
        if (x > 99999999) return 32'h99999999;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Behavioural model: counts down the fixed latency, then publishes the precomputed result.
    logic        m_busy, m_done, m_ovf, m_res_ovf;
    logic [31:0] m_bcd, m_res;
    int          m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_bcd = '0;
            m_res = '0; m_res_ovf = 1'b0; m_cnt = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_bcd  = m_res;
                    m_ovf  = m_res_ovf;
                    m_done = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (start) begin
                if (hex_bypass) begin
                    m_res     = 32'(bin_in);
                    m_res_ovf = 1'b0;
                    m_cnt     = 1;
                end else begin
                    m_res     = dec_digits(bin_in);
                    m_res_ovf = (bin_in > 27'd99999999);
                    m_cnt     = 27;
                end
                m_busy = 1'b1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_busy", busy, m_busy);
            chk("cyc_done", done, m_done);
            chk("cyc_ovf",  overflow, m_ovf);
            chk("cyc_bcd",  bcd_out, m_bcd);
        end
    end

    // Accept one start, optionally pulse start at edges p1/p2 while busy, scramble inputs, time done.
    task automatic run_conv(input logic [26:0] val, input logic hx, input int exp_edges,
                            input int p1, input int p2, input string name);
        int edges;
        @(negedge clk);
        start = 1'b1; hex_bypass = hx; bin_in = val;
        @(negedge clk);
        start = 1'b0;
        edges = 0;
        while (!done && edges < 60) begin
            start      = (edges == p1 || edges == p2);
            bin_in     = 27'($urandom);
            hex_bypass = 1'($urandom);
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        chk({name, "_latency"}, edges, exp_edges);
    endtask

    initial begin
        int edges;
        rst_n = 1'b0; start = 1'b0; hex_bypass = 1'b0; bin_in = '0;
        #3;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ovf",  overflow, 1'b0);
        chk("rst_bcd",  bcd_out, 32'h0);

        chk("model_pin_a", dec_digits(27'd12345678), 32'h12345678);
        chk("model_pin_b", dec_digits(27'd100000000), 32'h99999999);
        chk("model_pin_c", dec_digits(27'd42), 32'h00000042);

        @(negedge clk); @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        run_conv(27'd12345678, 1'b0, 27, -1, -1, "c12345678");
        chk("c12345678_bcd", bcd_out, 32'h12345678);
        chk("c12345678_ovf", overflow, 1'b0);

        run_conv(27'd0, 1'b0, 27, -1, -1, "c0");
        chk("c0_bcd", bcd_out, 32'h00000000);

        run_conv(27'd99999999, 1'b0, 27, -1, -1, "cmax");
        chk("cmax_bcd", bcd_out, 32'h99999999);
        chk("cmax_ovf", overflow, 1'b0);

        run_conv(27'd100000000, 1'b0, 27, -1, -1, "covf");
        chk("covf_bcd", bcd_out, 32'h99999999);
        chk("covf_ovf", overflow, 1'b1);

        run_conv(27'h7FFFFFF, 1'b0, 27, -1, -1, "cfull");
        chk("cfull_bcd", bcd_out, 32'h99999999);
        chk("cfull_ovf", overflow, 1'b1);

        run_conv(27'd42, 1'b0, 27, 5, 20, "c42");
        chk("c42_bcd", bcd_out, 32'h00000042);
        chk("c42_ovf", overflow, 1'b0);

        // start held high through done: the next conversion is accepted on the done cycle.
        @(negedge clk);
        start = 1'b1; hex_bypass = 1'b0; bin_in = 27'd123;
        @(negedge clk);
        edges = 0;
        while (!done && edges < 60) begin
            @(negedge clk);
            edges++;
        end
        chk("b2b_first_latency", edges, 27);
        chk("b2b_first_bcd", bcd_out, 32'h00000123);
        bin_in = 27'd456;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_second_busy", busy, 1'b1);
        edges = 0;
        while (!done && edges < 60) begin
            @(negedge clk);
            edges++;
        end
        chk("b2b_second_latency", edges, 27);
        chk("b2b_second_bcd", bcd_out, 32'h00000456);

        run_conv(27'hABCDEF, 1'b1, 1, -1, -1, "hex");
        chk("hex_bcd", bcd_out, 32'h00ABCDEF);
        chk("hex_ovf", overflow, 1'b0);

        run_conv(27'd9, 1'b0, 27, -1, -1, "c9");
        chk("c9_bcd", bcd_out, 32'h00000009);

        // Reset in the middle of a conversion takes effect without a clock edge.
        @(negedge clk);
        start = 1'b1; hex_bypass = 1'b0; bin_in = 27'd87654321;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_bcd",  bcd_out, 32'h0);
        chk("midrst_ovf",  overflow, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        edges = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) edges++;
        end
        chk("midrst_no_done", edges, 0);

        run_conv(27'd55, 1'b0, 27, -1, -1, "c55");
        chk("c55_bcd", bcd_out, 32'h00000055);
        repeat (100) begin
            @(negedge clk);
            bin_in     = 27'($urandom);
            hex_bypass = 1'($urandom);
        end
        @(negedge clk);
        chk("hold_bcd", bcd_out, 32'h00000055);
        chk("hold_ovf", overflow, 1'b0);

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
